// File: rtl/nxn_tic_tac_toe_game.sv
// nxn_tic_tac_toe_game: N x N tic-tac-toe engine with alternating player/computer moves, legality check, win/draw detection.
// Ports: clock/reset (sync, active-high); play/pc move strobes with player_position/computer_position (row-major cell index);
// board (2 bits per cell: 00 empty, 01 player, 10 computer); who (00 playing, 01 player, 10 computer, 11 draw);
// turn (0 player, 1 computer); illegal (one-cycle reject pulse); move_count (marks placed); game_over (who != 00).
module nxn_tic_tac_toe_game #(
  parameter int N = 3,
  localparam int CELLS = N * N,
  localparam int POS_W = $clog2(CELLS),
  localparam int CNT_W = $clog2(CELLS + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               play,
  input  logic               pc,
  input  logic [POS_W-1:0]   player_position,
  input  logic [POS_W-1:0]   computer_position,
  output logic [2*CELLS-1:0] board,
  output logic [1:0]         who,
  output logic               turn,
  output logic               illegal,
  output logic [CNT_W-1:0]   move_count,
  output logic               game_over
);
  typedef enum logic [1:0] {P_TURN, C_TURN, CHECK, OVER} state_t;
  state_t r_state, w_state_nx;
  logic [2*CELLS-1:0] r_board, w_board_nx, w_pboard, w_cboard;
  logic [1:0] r_who, w_who_nx, w_code;
  logic r_turn, w_turn_nx, r_illegal, w_illegal_nx, w_win;
  logic [CNT_W-1:0] r_count, w_count_nx;
  // padded to the full position range so out-of-range indices read as "not free"
  logic [2**POS_W-1:0] w_free;
  logic [CELLS-1:0] w_match;
  logic [N-1:0] w_row, w_col, w_d0, w_d1;
  logic [N-1:0][N-1:0] w_colm;
  // turn still names the mover while in CHECK, so it selects the code to test
  assign w_code = r_turn ? 2'b10 : 2'b01;
  genvar i, r, c;
  for (i = 0; i < 2**POS_W; i++) begin : g_free
    if (i < CELLS) begin : g_in
      assign w_free[i] = r_board[2*i+:2] == 2'b00;
      assign w_pboard[2*i+:2] = player_position == POS_W'(i) ? 2'b01 : r_board[2*i+:2];
      assign w_cboard[2*i+:2] = computer_position == POS_W'(i) ? 2'b10 : r_board[2*i+:2];
      assign w_match[i] = r_board[2*i+:2] == w_code;
    end else begin : g_out
      assign w_free[i] = 1'b0;
    end
  end
  for (r = 0; r < N; r++) begin : g_line
    for (c = 0; c < N; c++) begin : g_col
      assign w_colm[c][r] = w_match[r*N+c];
    end
    assign w_row[r] = &w_match[r*N+:N];
    assign w_col[r] = &w_colm[r];
    assign w_d0[r] = w_match[r*N+r];
    assign w_d1[r] = w_match[r*N+N-1-r];
  end
  assign w_win = |w_row | |w_col | &w_d0 | &w_d1;
  always_comb begin
    w_state_nx = r_state;
    w_board_nx = r_board;
    w_who_nx = r_who;
    w_turn_nx = r_turn;
    w_count_nx = r_count;
    w_illegal_nx = 1'b0;
    case (r_state)
      P_TURN: if (play) begin
        if (w_free[player_position]) begin
          w_board_nx = w_pboard;
          w_count_nx = r_count + CNT_W'(1);
          w_state_nx = CHECK;
        end else w_illegal_nx = 1'b1;
      end
      C_TURN: if (pc) begin
        if (w_free[computer_position]) begin
          w_board_nx = w_cboard;
          w_count_nx = r_count + CNT_W'(1);
          w_state_nx = CHECK;
        end else w_illegal_nx = 1'b1;
      end
      CHECK: begin
        if (w_win) begin
          w_who_nx = w_code;
          w_state_nx = OVER;
        end else if (r_count == CNT_W'(CELLS)) begin
          w_who_nx = 2'b11;
          w_state_nx = OVER;
        end else begin
          w_turn_nx = ~r_turn;
          w_state_nx = r_turn ? P_TURN : C_TURN;
        end
      end
      default: ;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= P_TURN;
      r_board <= '0;
      r_who <= 2'b00;
      r_turn <= 1'b0;
      r_illegal <= 1'b0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nx;
      r_board <= w_board_nx;
      r_who <= w_who_nx;
      r_turn <= w_turn_nx;
      r_illegal <= w_illegal_nx;
      r_count <= w_count_nx;
    end
  end
  assign board = r_board;
  assign who = r_who;
  assign turn = r_turn;
  assign illegal = r_illegal;
  assign move_count = r_count;
  assign game_over = |r_who;
endmodule

// File: tb/tb_nxn_tic_tac_toe_game.sv
// tb_nxn_tic_tac_toe_game: directed bench for N=3 and N=4 engines checked every cycle against a board-level model.
module tb_nxn_tic_tac_toe_game;
  logic clock = 0, rst = 1, act = 0, play = 0, pc = 0;
  logic [3:0] ppos = 0, cpos = 0;
  logic [17:0] board3;
  logic [31:0] board4;
  logic [1:0] who3, who4;
  logic turn3, turn4, ill3, ill4, go3, go4;
  logic [3:0] cnt3;
  logic [4:0] cnt4;
  int mn = 3;
  int mb[64];
  int m_who, m_turn, m_cnt, m_ill, m_pend;
  bit chk_en = 0;
  int total = 0, bad = 0;
  always #5 clock = ~clock;
  nxn_tic_tac_toe_game #(.N(3)) u3 (
    .clock(clock), .reset(rst | act), .play(play), .pc(pc),
    .player_position(ppos), .computer_position(cpos),
    .board(board3), .who(who3), .turn(turn3), .illegal(ill3),
    .move_count(cnt3), .game_over(go3)
  );
  nxn_tic_tac_toe_game #(.N(4)) u4 (
    .clock(clock), .reset(rst | !act), .play(play), .pc(pc),
    .player_position(ppos), .computer_position(cpos),
    .board(board4), .who(who4), .turn(turn4), .illegal(ill4),
    .move_count(cnt4), .game_over(go4)
  );
  wire [127:0] d_board = act ? 128'(board4) : 128'(board3);
  wire [1:0] d_who = act ? who4 : who3;
  wire d_turn = act ? turn4 : turn3;
  wire d_ill = act ? ill4 : ill3;
  wire d_go = act ? go4 : go3;
  wire [4:0] d_cnt = act ? cnt4 : 5'(cnt3);
  task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask
  function automatic bit won(input int code);
    bit any, ok, d0, d1;
    any = 0;
    d0 = 1;
    d1 = 1;
    for (int r = 0; r < mn; r++) begin
      ok = 1;
      for (int c = 0; c < mn; c++) if (mb[r*mn+c] != code) ok = 0;
      if (ok) any = 1;
      ok = 1;
      for (int c = 0; c < mn; c++) if (mb[c*mn+r] != code) ok = 0;
      if (ok) any = 1;
      if (mb[r*mn+r] != code) d0 = 0;
      if (mb[r*mn+mn-1-r] != code) d1 = 0;
    end
    return any | d0 | d1;
  endfunction
  function automatic logic [127:0] mboard();
    logic [127:0] v;
    v = '0;
    for (int k = 0; k < mn * mn; k++) v[2*k+:2] = mb[k][1:0];
    return v;
  endfunction
  task automatic step();
    int pos;
    bit s;
    m_ill = 0;
    if (rst) begin
      foreach (mb[k]) mb[k] = 0;
      m_who = 0;
      m_turn = 0;
      m_cnt = 0;
      m_pend = 0;
    end else if (m_pend != 0) begin
      m_pend = 0;
      if (won(m_turn != 0 ? 2 : 1)) m_who = m_turn != 0 ? 2 : 1;
      else if (m_cnt == mn * mn) m_who = 3;
      else m_turn = m_turn != 0 ? 0 : 1;
    end else if (m_who == 0) begin
      s = m_turn != 0 ? pc : play;
      pos = m_turn != 0 ? int'(cpos) : int'(ppos);
      if (s) begin
        if (pos < mn * mn && mb[pos] == 0) begin
          mb[pos] = m_turn != 0 ? 2 : 1;
          m_cnt++;
          m_pend = 1;
        end else m_ill = 1;
      end
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
    step();
  endtask
  task automatic mv(input bit c, input int pos, input int hold);
    if (c) begin
      pc = 1;
      cpos = 4'(pos);
    end else begin
      play = 1;
      ppos = 4'(pos);
    end
    repeat (hold) tick();
    play = 0;
    pc = 0;
  endtask
  task automatic restart();
    rst = 1;
    tick();
    rst = 0;
  endtask
  always @(negedge clock) begin
    if (chk_en) begin
      chk("board", d_board, mboard());
      chk("who", 128'(d_who), 128'(m_who));
      chk("turn", 128'(d_turn), 128'(m_turn));
      chk("illegal", 128'(d_ill), 128'(m_ill));
      chk("move_count", 128'(d_cnt), 128'(m_cnt));
      chk("game_over", 128'(d_go), 128'(m_who != 0));
    end
  end
  initial begin
    int big;
    tick();
    chk_en = 1;
    tick();
    rst = 0;
    // player wins on the top row
    mv(0, 0, 2); mv(1, 4, 2); mv(0, 1, 2); mv(1, 8, 2); mv(0, 2, 1);
    chk("t1_who_before", 128'(d_who), 128'd0);
    chk("t1_count", 128'(d_cnt), 128'd5);
    tick();
    chk("t1_who", 128'(d_who), 128'd1);
    chk("t1_game_over", 128'(d_go), 128'd1);
    chk("t1_board", d_board, 128'(18'b100000001000010101));
    // frozen after the win
    play = 1; ppos = 5; pc = 1; cpos = 6;
    repeat (3) tick();
    play = 0; pc = 0;
    chk("t5_freeze_ill", 128'(d_ill), 128'd0);
    chk("t5_freeze_board", d_board, 128'(18'b100000001000010101));
    // mid-game reset with play held
    restart();
    mv(0, 0, 2); mv(1, 4, 2);
    play = 1; ppos = 3; rst = 1;
    tick();
    chk("t5_rst_board", d_board, 128'd0);
    chk("t5_rst_count", 128'(d_cnt), 128'd0);
    chk("t5_rst_turn", 128'(d_turn), 128'd0);
    rst = 0;
    tick();
    chk("t5_first_move", d_board, 128'h40);
    play = 0;
    tick();
    // computer wins on the anti-diagonal
    restart();
    mv(0, 0, 2); mv(1, 4, 2); mv(0, 1, 2); mv(1, 2, 2); mv(0, 5, 2); mv(1, 6, 2);
    chk("t2_who", 128'(d_who), 128'd2);
    chk("t2_count", 128'(d_cnt), 128'd6);
    chk("t2_turn", 128'(d_turn), 128'd1);
    // rejected and ignored strobes
    restart();
    pc = 1; cpos = 4;
    repeat (2) tick();
    pc = 0;
    chk("t3_pc_in_pturn_ill", 128'(d_ill), 128'd0);
    chk("t3_pc_in_pturn_board", d_board, 128'd0);
    mv(0, 0, 2);
    pc = 1; cpos = 0;
    tick();
    chk("t3_c0_ill", 128'(d_ill), 128'd1);
    chk("t3_c0_board", d_board, 128'h1);
    chk("t3_c0_turn", 128'(d_turn), 128'd1);
    tick();
    pc = 0;
    tick();
    chk("t3_ill_drop", 128'(d_ill), 128'd0);
    mv(1, 9, 1);
    chk("t3_c9_ill", 128'(d_ill), 128'd1);
    play = 1; ppos = 5;
    tick();
    play = 0;
    chk("t3_play_in_cturn", 128'(d_ill), 128'd0);
    mv(1, 4, 2);
    chk("t3_c4_board", d_board, 128'h201);
    chk("t3_c4_count", 128'(d_cnt), 128'd2);
    // draw
    restart();
    mv(0, 0, 2); mv(1, 2, 2); mv(0, 1, 2); mv(1, 4, 2); mv(0, 5, 2);
    mv(1, 3, 2); mv(0, 6, 2); mv(1, 7, 2); mv(0, 8, 2);
    chk("t4_who", 128'(d_who), 128'd3);
    chk("t4_count", 128'(d_cnt), 128'd9);
    // 4x4 column win; position 16 wraps to the occupied cell 0 on a 4-bit port
    rst = 1;
    tick();
    act = 1;
    mn = 4;
    tick();
    rst = 0;
    mv(0, 0, 2); mv(1, 1, 2);
    big = 16;
    play = 1; ppos = big[3:0];
    tick();
    play = 0;
    chk("t6_ill", 128'(d_ill), 128'd1);
    tick();
    mv(0, 4, 2); mv(1, 2, 2); mv(0, 8, 2); mv(1, 3, 2); mv(0, 12, 2);
    chk("t6_who", 128'(d_who), 128'd1);
    chk("t6_count", 128'(d_cnt), 128'd7);
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
